// File: rtl/starfield_pkg.sv
// Shared constants, types and helpers for the parallax starfield: LFSR taps,
// layer colours, sweep FSM encoding and the reset-position functions.
package starfield_pkg;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  // Feedback from bits 16,14,13,11 (1-based), i.e. indices 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [2:0] COL_FAR  = 3'b001;
  localparam logic [2:0] COL_MID  = 3'b011;
  localparam logic [2:0] COL_NEAR = 3'b111;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  function automatic logic [9:0] init_x(input int i, input int count, input int h_res);
    return 10'(i * (h_res / count) + 8);
  endfunction

  function automatic logic [9:0] init_y(input int i, input int v_res);
    return 10'((i * 73) % v_res);
  endfunction

  // The nearest layer is always white, so a single-layer field is white too.
  function automatic logic [2:0] layer_colour(input int l, input int layers);
    if (l == layers - 1) return COL_NEAR;
    else if (l == 0)     return COL_FAR;
    else                 return COL_MID;
  endfunction

endpackage

// File: rtl/starfield_engine_if.sv
// Pixel query, frame control and status signals between the VGA pipeline and
// the starfield engine.
interface starfield_engine_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_tick;
  logic       pause;
  logic [2:0] star_rgb;
  logic       star_on;
  logic       busy;

  modport master (
    output x, y, frame_tick, pause,
    input  star_rgb, star_on, busy
  );

  modport slave (
    input  x, y, frame_tick, pause,
    output star_rgb, star_on, busy
  );
endinterface

// File: rtl/starfield_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; keeps stepping regardless of pause so
// respawn positions stay unpredictable.
module starfield_lfsr16
  import starfield_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk25,
  input  logic        reset,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/starfield_engine.sv
// Multi-layer parallax starfield: positions are swept one star per cycle after
// each frame tick, and every pixel is hit-tested against all stars in parallel.
module starfield_engine
  import starfield_pkg::*;
#(
  parameter int          STAR_COUNT = 32,
  parameter int          LAYERS     = 3,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input logic               clk25,
  input logic               reset,
  starfield_engine_if.slave bus
);

  localparam int               IDX_W    = $clog2(STAR_COUNT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STAR_COUNT - 1);
  localparam logic [10:0]      H_RES_W  = 11'(H_RES);
  localparam logic [10:0]      V_RES_W  = 11'(V_RES);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [9:0]       star_x [STAR_COUNT];
  logic [9:0]       star_y [STAR_COUNT];
  logic [15:0]      lfsr;
  logic             lfsr_unused;
  logic [10:0]      speed;
  logic [10:0]      ny;
  logic [10:0]      r_ext;
  logic [9:0]       respawn_x;
  logic             hit_any;
  logic [2:0]       hit_rgb;
  logic             star_on_q;
  logic [2:0]       star_rgb_q;

  starfield_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk25 (clk25),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:10];

  // With 2*H_RES >= 1024 a single subtraction folds any 10-bit value on screen.
  always_comb begin
    speed     = 11'((int'(idx) % LAYERS) + 1);
    ny        = {1'b0, star_y[idx]} + speed;
    r_ext     = {1'b0, lfsr[9:0]};
    respawn_x = (r_ext < H_RES_W) ? r_ext[9:0] : 10'(r_ext - H_RES_W);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.frame_tick && !bus.pause) state_next = UPDATE;
      UPDATE:  if (idx == IDX_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < STAR_COUNT; i++) begin
        star_x[i] <= init_x(i, STAR_COUNT, H_RES);
        star_y[i] <= init_y(i, V_RES);
      end
    end else begin
      state <= state_next;
      if (state == UPDATE) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        if (ny >= V_RES_W) begin
          star_y[idx] <= 10'(ny - V_RES_W);
          star_x[idx] <= respawn_x;
        end else begin
          star_y[idx] <= ny[9:0];
        end
      end else begin
        idx <= '0;
      end
    end
  end

  // Layers are scanned near-last so the nearest overlapping star sets the colour.
  always_comb begin
    hit_any = 1'b0;
    hit_rgb = 3'b000;
    for (int l = 0; l < LAYERS; l++) begin
      for (int i = l; i < STAR_COUNT; i += LAYERS) begin
        if (star_x[i] == bus.x && star_y[i] == bus.y) begin
          hit_any = 1'b1;
          hit_rgb = layer_colour(l, LAYERS);
        end
      end
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      star_on_q  <= 1'b0;
      star_rgb_q <= 3'b000;
    end else begin
      star_on_q  <= hit_any;
      star_rgb_q <= hit_rgb;
    end
  end

  assign bus.star_on  = star_on_q;
  assign bus.star_rgb = star_rgb_q;
  assign bus.busy     = (state == UPDATE);

endmodule
